// File: rtl/maint_if.sv
// rtl/maint_if.sv - maintenance instruction port between refresh scheduler and receiver
interface maint_if;
  logic        maint_en;
  logic        maint_ack;
  logic [31:0] maint_instr;

  modport master (output maint_en, output maint_instr, input maint_ack);
  modport slave  (input maint_en, input maint_instr, output maint_ack);
endinterface

// File: rtl/maint_refresh_scheduler.sv
// rtl/maint_refresh_scheduler.sv - tREFI timer, pending-refresh accounting and maintenance sequence FSM
module maint_refresh_scheduler #(
  parameter int          MAX_PENDING = 8,
  parameter int          THRESH      = 1,
  parameter logic [3:0]  END_ISEQ    = 4'hF,
  parameter logic [31:0] INSTR_PRE   = 32'h0,
  parameter logic [31:0] INSTR_WRP   = 32'h0,
  parameter logic [31:0] INSTR_REF   = 32'h0,
  parameter logic [31:0] INSTR_WRFC  = 32'h0,
  parameter logic [31:0] INSTR_END   = {END_ISEQ, 28'h0}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] trefi,
  maint_if.master     maint,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        overflow
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WRP, S_REF, S_WRFC, S_END} state_t;

  localparam logic [4:0] MAX5   = 5'(MAX_PENDING);
  localparam logic [3:0] THRESH4 = 4'(THRESH);

  state_t      state;
  logic [15:0] timer;
  logic [3:0]  n_lat;
  logic [3:0]  ref_cnt;
  logic        tick;
  logic        accept;
  logic [3:0]  dec;
  logic [4:0]  pend_sum;

  assign tick     = enable && (trefi != 16'd0) && (timer >= trefi - 16'd1);
  assign accept   = maint.maint_en && maint.maint_ack;
  assign dec      = (state == S_END && accept) ? n_lat : 4'd0;
  // pending >= n_lat always holds, so the difference never wraps
  assign pend_sum = {1'b0, pending} + {4'd0, tick} - {1'b0, dec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 16'd0;
    end else if (!enable) begin
      timer <= 16'd0;
    end else if (trefi != 16'd0) begin
      timer <= tick ? 16'd0 : timer + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      pending <= (pend_sum > MAX5) ? MAX5[3:0] : pend_sum[3:0];
      if (tick && ({1'b0, pending} == MAX5) && (dec == 4'd0))
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      maint.maint_en    <= 1'b0;
      maint.maint_instr <= 32'h0;
      busy              <= 1'b0;
      n_lat             <= 4'd0;
      ref_cnt           <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending >= THRESH4) begin
            state             <= S_PRE;
            maint.maint_en    <= 1'b1;
            maint.maint_instr <= INSTR_PRE;
            n_lat             <= pending;
            busy              <= 1'b1;
          end
        end
        S_PRE: begin
          // Until PRE is taken the receiver has not started, so the count can still grow
          n_lat <= pending;
          if (accept) begin
            state             <= S_WRP;
            maint.maint_instr <= INSTR_WRP;
          end
        end
        S_WRP: begin
          if (accept) begin
            state             <= S_REF;
            ref_cnt           <= 4'd0;
            maint.maint_instr <= INSTR_REF;
          end
        end
        S_REF: begin
          if (accept) begin
            state             <= S_WRFC;
            maint.maint_instr <= INSTR_WRFC;
          end
        end
        S_WRFC: begin
          if (accept) begin
            if (ref_cnt + 4'd1 == n_lat) begin
              state             <= S_END;
              maint.maint_instr <= INSTR_END;
            end else begin
              state             <= S_REF;
              ref_cnt           <= ref_cnt + 4'd1;
              maint.maint_instr <= INSTR_REF;
            end
          end
        end
        S_END: begin
          if (accept) begin
            state          <= S_IDLE;
            maint.maint_en <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          maint.maint_en <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maint_refresh_scheduler.sv
// tb/tb_maint_refresh_scheduler.sv - directed scoreboard bench for maint_refresh_scheduler
module tb_maint_refresh_scheduler;

  localparam logic [31:0] W_PRE  = 32'h1000_00A1;
  localparam logic [31:0] W_WRP  = 32'h2000_00B2;
  localparam logic [31:0] W_REF  = 32'h3000_00C3;
  localparam logic [31:0] W_WRFC = 32'h4000_00D4;
  localparam logic [31:0] W_END  = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] trefi = 16'd0;
  logic        busy;
  logic [3:0]  pending;
  logic        overflow;

  maint_if bus();

  maint_refresh_scheduler #(
    .MAX_PENDING(8), .THRESH(1), .END_ISEQ(4'hF),
    .INSTR_PRE(W_PRE), .INSTR_WRP(W_WRP), .INSTR_REF(W_REF),
    .INSTR_WRFC(W_WRFC), .INSTR_END(W_END)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trefi(trefi),
    .maint(bus.master), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change at negedge+1; the monitor looks at negedge+4, before the accepting posedge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push5();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    exp_q.push_back(W_REF);
    exp_q.push_back(W_WRFC);
    exp_q.push_back(W_END);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.maint_ack = 1'b0;
    enable = 1'b0;
    trefi = 16'd0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic serve_until(input logic [31:0] word);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (bus.maint_en && bus.maint_instr == word) begin
        bus.maint_ack = 1'b0;
        found = 1'b1;
      end else begin
        bus.maint_ack = 1'b1;
      end
    end
    bus.maint_ack = 1'b0;
    chk($sformatf("reach_%h", word), {31'd0, found}, 32'd1);
  endtask

  task automatic serve_all();
    logic done = 1'b0;
    bus.maint_ack = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      cyc();
      if (!busy) done = 1'b1;
    end
    bus.maint_ack = 1'b0;
    chk("serve_all_done", {31'd0, done}, 32'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.maint_en && bus.maint_ack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h expected none", bus.maint_instr);
        end else begin
          chk("word", bus.maint_instr, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.maint_ack = 1'b0;
    #2;
    do_reset();
    chk("rst_en", {31'd0, bus.maint_en}, 32'd0);
    chk("rst_instr", bus.maint_instr, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // single refresh with ack held high: five words on consecutive cycles
    trefi = 16'd100; enable = 1'b1; bus.maint_ack = 1'b1;
    repeat (99) cyc();
    chk("t2_pend_before", {28'd0, pending}, 32'd0);
    cyc();
    chk("t2_pend_tick", {28'd0, pending}, 32'd1);
    chk("t2_en_idle", {31'd0, bus.maint_en}, 32'd0);
    push5();
    cyc();
    chk("t2_en_pre", {31'd0, bus.maint_en}, 32'd1);
    chk("t2_instr_pre", bus.maint_instr, W_PRE);
    repeat (5) cyc();
    chk("t2_q_empty", exp_q.size(), 32'd0);
    chk("t2_pend_after", {28'd0, pending}, 32'd0);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    enable = 1'b0; bus.maint_ack = 1'b0;

    // three ticks while stalled, then one sequence with three refreshes
    do_reset();
    trefi = 16'd100; enable = 1'b1;
    repeat (300) cyc();
    chk("t3_pend3", {28'd0, pending}, 32'd3);
    chk("t3_en_held", {31'd0, bus.maint_en}, 32'd1);
    chk("t3_instr_pre", bus.maint_instr, W_PRE);
    enable = 1'b0;
    cyc();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(W_REF);
      exp_q.push_back(W_WRFC);
    end
    exp_q.push_back(W_END);
    serve_all();
    chk("t3_pend0", {28'd0, pending}, 32'd0);
    chk("t3_q_empty", exp_q.size(), 32'd0);

    // tick lands on the END accept cycle of an n_lat=2 sequence
    do_reset();
    trefi = 16'd1; enable = 1'b1;
    cyc();
    cyc();
    enable = 1'b0;
    chk("t4_pend2", {28'd0, pending}, 32'd2);
    cyc();
    cyc();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    exp_q.push_back(W_REF);
    exp_q.push_back(W_WRFC);
    exp_q.push_back(W_REF);
    exp_q.push_back(W_WRFC);
    serve_until(W_END);
    exp_q.push_back(W_END);
    bus.maint_ack = 1'b1; enable = 1'b1;
    cyc();
    bus.maint_ack = 1'b0; enable = 1'b0;
    chk("t4_pend1", {28'd0, pending}, 32'd1);
    chk("t4_gap_en", {31'd0, bus.maint_en}, 32'd0);
    chk("t4_gap_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("t4_rereq_en", {31'd0, bus.maint_en}, 32'd1);
    chk("t4_rereq_pre", bus.maint_instr, W_PRE);
    push5();
    serve_all();
    chk("t4_pend0", {28'd0, pending}, 32'd0);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);

    // saturation at MAX_PENDING and sticky overflow
    do_reset();
    trefi = 16'd1; enable = 1'b1;
    repeat (8) cyc();
    chk("t5_pend8", {28'd0, pending}, 32'd8);
    chk("t5_ovf_before", {31'd0, overflow}, 32'd0);
    cyc();
    enable = 1'b0;
    chk("t5_pend_sat", {28'd0, pending}, 32'd8);
    chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
    cyc();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(W_REF);
      exp_q.push_back(W_WRFC);
    end
    exp_q.push_back(W_END);
    serve_all();
    chk("t5_pend0", {28'd0, pending}, 32'd0);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    do_reset();
    chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);

    // enable dropped during REF: sequence completes, timer restarts from zero
    trefi = 16'd20; enable = 1'b1;
    repeat (20) cyc();
    chk("t6_pend1", {28'd0, pending}, 32'd1);
    cyc();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    serve_until(W_REF);
    enable = 1'b0;
    repeat (30) cyc();
    chk("t6_pend_hold", {28'd0, pending}, 32'd1);
    chk("t6_busy_hold", {31'd0, busy}, 32'd1);
    chk("t6_instr_ref", bus.maint_instr, W_REF);
    exp_q.push_back(W_REF);
    exp_q.push_back(W_WRFC);
    exp_q.push_back(W_END);
    serve_all();
    chk("t6_pend0", {28'd0, pending}, 32'd0);
    repeat (30) cyc();
    chk("t6_no_tick", {28'd0, pending}, 32'd0);
    enable = 1'b1;
    repeat (19) cyc();
    chk("t6_pend_pre_tick", {28'd0, pending}, 32'd0);
    cyc();
    enable = 1'b0;
    chk("t6_pend_tick", {28'd0, pending}, 32'd1);

    // asynchronous reset while stalled in WRFC
    cyc();
    exp_q.push_back(W_PRE);
    exp_q.push_back(W_WRP);
    exp_q.push_back(W_REF);
    serve_until(W_WRFC);
    chk("t1_instr_wrfc", bus.maint_instr, W_WRFC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_en_async", {31'd0, bus.maint_en}, 32'd0);
    chk("t1_pend_async", {28'd0, pending}, 32'd0);
    chk("t1_busy_async", {31'd0, busy}, 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.maint_ack = 1'b1;
    repeat (3) cyc();
    bus.maint_ack = 1'b0;
    chk("t1_no_end", {31'd0, bus.maint_en}, 32'd0);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
